// File: rtl/i_fetch.sv
// rtl/i_fetch.sv - MIPS instruction-fetch stage: PC, imem req/ack handshake, IF/ID register
// Holds one stalled fetch in a skid buffer and drains orphaned requests after a redirect.
module i_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] npc_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] skid_instr, skid_instr_n;
  logic [31:0] skid_npc, skid_npc_n;
  logic [31:0] drop_addr, drop_addr_n;
  logic [31:0] instr_n, npc_n;
  logic        valid_n;
  logic [31:0] pc_plus4;
  logic [31:0] target;

  assign pc_plus4 = pc + 32'd4;
  assign target   = {redirect_pc[31:2], 2'b00};

  // DROP keeps the orphaned address on the bus so the memory sees a stable request
  assign imem_req  = !rst && (state != HOLD);
  assign imem_addr = (state == DROP) ? drop_addr : pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= FETCH;
      pc              <= RESET_PC;
      skid_instr      <= 32'h0;
      skid_npc        <= 32'h0;
      drop_addr       <= 32'h0;
      instruction_out <= 32'h0;
      npc_out         <= 32'h0;
      valid_out       <= 1'b0;
    end else begin
      state           <= state_n;
      pc              <= pc_n;
      skid_instr      <= skid_instr_n;
      skid_npc        <= skid_npc_n;
      drop_addr       <= drop_addr_n;
      instruction_out <= instr_n;
      npc_out         <= npc_n;
      valid_out       <= valid_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    skid_instr_n = skid_instr;
    skid_npc_n   = skid_npc;
    drop_addr_n  = drop_addr;
    instr_n      = instruction_out;
    npc_n        = npc_out;
    valid_n      = valid_out;

    if (redirect) begin
      instr_n = 32'h0;
      valid_n = 1'b0;
      pc_n    = target;
      if (state == FETCH && !imem_ack) begin
        state_n     = DROP;
        drop_addr_n = pc;
      end else if (state == DROP && !imem_ack) begin
        state_n = DROP;
      end else begin
        state_n = FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            if (stall) begin
              skid_instr_n = imem_rdata;
              skid_npc_n   = pc_plus4;
              state_n      = HOLD;
            end else begin
              instr_n = imem_rdata;
              npc_n   = pc_plus4;
              valid_n = 1'b1;
              pc_n    = pc_plus4;
            end
          end else if (!stall) begin
            instr_n = 32'h0;
            valid_n = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_n = skid_instr;
            npc_n   = skid_npc;
            valid_n = 1'b1;
            pc_n    = pc_plus4;
            state_n = FETCH;
          end
        end
        DROP: begin
          if (imem_ack) begin
            state_n = FETCH;
            if (!stall) begin
              instr_n = 32'h0;
              valid_n = 1'b0;
            end
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_i_fetch.sv
// tb/tb_i_fetch.sv - directed and random checks of i_fetch against a behavioural fetch model
module tb_i_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instruction_out;
  logic [31:0] npc_out;
  logic        valid_out;

  int n_assert = 0;
  int n_fail   = 0;
  int lat      = 0;   // fixed ack latency in cycles; negative selects random acks
  int wait_cnt = 0;

  // Behavioural view: a program counter, an optional parked instruction,
  // an optional stale request that must be drained, and the word decode sees.
  logic [31:0] m_pc = 32'h0;
  bit          m_parked = 1'b0;
  logic [31:0] m_park_instr = 32'h0, m_park_npc = 32'h0;
  bit          m_stale = 1'b0;
  logic [31:0] m_stale_addr = 32'h0;
  logic [31:0] m_instr = 32'h0, m_npc = 32'h0;
  logic        m_valid = 1'b0;

  i_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction_out(instruction_out), .npc_out(npc_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs after negedge, act as memory, check, advance model, check IF/ID.
  task automatic cyc(input bit r, input bit s, input bit rd, input logic [31:0] rpc);
    logic [31:0] exp_addr;
    bit          exp_req;
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    #1;
    if (r)              imem_ack = 1'b1;
    else if (!imem_req) imem_ack = 1'b0;
    else if (lat < 0)   imem_ack = ($urandom_range(0, 2) == 0);
    else                imem_ack = (wait_cnt >= lat);
    imem_rdata = imem_addr;
    #1;
    exp_req  = !r && !m_parked;
    exp_addr = m_stale ? m_stale_addr : m_pc;
    chk("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, exp_addr);

    if (r) begin
      m_pc = 32'h0; m_parked = 0; m_stale = 0;
      m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
    end else if (rd) begin
      m_instr = 32'h0; m_valid = 1'b0;
      if (!m_parked && !imem_ack) begin
        m_stale_addr = exp_addr;
        m_stale = 1;
      end else begin
        m_stale = 0;
      end
      m_parked = 0;
      m_pc = rpc & 32'hFFFF_FFFC;
    end else if (m_parked) begin
      if (!s) begin
        m_instr = m_park_instr; m_npc = m_park_npc; m_valid = 1'b1;
        m_pc = m_pc + 32'd4; m_parked = 0;
      end
    end else if (m_stale) begin
      if (imem_ack) begin
        m_stale = 0;
        if (!s) begin m_instr = 32'h0; m_valid = 1'b0; end
      end
    end else if (imem_ack) begin
      if (s) begin
        m_park_instr = exp_addr; m_park_npc = m_pc + 32'd4; m_parked = 1;
      end else begin
        m_instr = exp_addr; m_npc = m_pc + 32'd4; m_valid = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end else if (!s) begin
      m_instr = 32'h0; m_valid = 1'b0;
    end

    wait_cnt = (r || !imem_req || imem_ack) ? 0 : wait_cnt + 1;
    @(posedge clk);
    @(negedge clk);
    chk("instruction_out", instruction_out, m_instr);
    chk("npc_out", npc_out, m_npc);
    chk("valid_out", {31'h0, valid_out}, {31'h0, m_valid});
  endtask

  initial begin
    @(negedge clk);
    // zero-wait memory after reset
    lat = 0;
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    chk("reset_valid", {31'h0, valid_out}, 32'h0);
    repeat (3) cyc(0, 0, 0, 0);
    chk("seq_instr", instruction_out, 32'h8);
    chk("seq_npc", npc_out, 32'hC);
    // stall while acked, held for three cycles, then release
    repeat (3) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("release_instr", instruction_out, 32'hC);
    chk("release_npc", npc_out, 32'h10);
    cyc(0, 0, 0, 0);
    // redirect with simultaneous stall
    cyc(0, 1, 1, 32'h100);
    chk("redir_bubble", {31'h0, valid_out}, 32'h0);
    cyc(0, 0, 0, 0);
    chk("redir_instr", instruction_out, 32'h100);
    chk("redir_npc", npc_out, 32'h104);
    // two-cycle memory latency
    lat = 2;
    repeat (8) cyc(0, 0, 0, 0);
    // redirect while a request is outstanding, then drain
    cyc(0, 0, 1, 32'h10);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h202);
    repeat (6) cyc(0, 0, 0, 0);
    // wrap-around at the top of the address space
    lat = 0;
    cyc(0, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    chk("wrap_npc", npc_out, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    // reset while in HOLD
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("rst_hold_instr", instruction_out, 32'h0);
    chk("rst_hold_npc", npc_out, 32'h0);
    chk("rst_hold_valid", {31'h0, valid_out}, 32'h0);
    cyc(0, 0, 0, 0);
    chk("rst_hold_refetch", instruction_out, 32'h0);
    chk("rst_hold_refetch_npc", npc_out, 32'h4);
    // random traffic
    lat = -1;
    for (int i = 0; i < 600; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 3),
          ($urandom_range(0, 9) == 0), tgt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
